// File: rtl/lif_step_scheduler.sv
// Time-multiplexed leaky integrate-and-fire controller: one datapath sweeps N_NEURONS per step.
// Optional per-neuron refractory counters are enabled with `define LIF_REFRACTORY_EN.
module lif_step_scheduler #(
    parameter int unsigned N_NEURONS    = 4,
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned THRESHOLD    = 200,
    parameter int unsigned REFRAC_STEPS = 2,
    localparam int unsigned IDXW        = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cur_wr_en,
    input  logic [IDXW-1:0]      cur_wr_idx,
    input  logic [WIDTH-1:0]     cur_wr_data,
    input  logic                 step,
    output logic                 busy,
    output logic                 done,
    output logic [N_NEURONS-1:0] spike_vec,
    input  logic [IDXW-1:0]      rd_idx,
    output logic [WIDTH-1:0]     rd_state
);

    localparam int unsigned SUMW = WIDTH + 1;

    typedef enum logic [1:0] {IDLE, SWEEP, FINISH} fsm_t;

    fsm_t                 fsm_q, fsm_d;
    logic                 busy_d, done_d;
    logic                 start_c, upd_c, last_c;
    logic [IDXW-1:0]      idx_q;
    logic [N_NEURONS-1:0] acc_q;
    logic [WIDTH-1:0]     state_q [N_NEURONS];
    logic [WIDTH-1:0]     cur_q   [N_NEURONS];

    logic [WIDTH-1:0]     st_sel_c, cur_sel_c, sat_c, new_state_c;
    logic [SUMW-1:0]      sum_c;
    logic                 fire_c, spike_c;

    assign last_c   = (idx_q == IDXW'(N_NEURONS - 1));
    assign rd_state = state_q[rd_idx];

    // Next-state and registered-output decode
    always_comb begin
        fsm_d   = fsm_q;
        start_c = 1'b0;
        upd_c   = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (step) begin
                    fsm_d   = SWEEP;
                    start_c = 1'b1;
                end
            end
            SWEEP: begin
                upd_c = 1'b1;
                if (last_c) fsm_d = FINISH;
            end
            FINISH:  fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
        busy_d = (fsm_d != IDLE);
        done_d = (fsm_d == FINISH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    // Shared leak/integrate/fire datapath for the neuron at idx_q
    assign st_sel_c  = state_q[idx_q];
    assign cur_sel_c = cur_q[idx_q];
    assign sum_c     = SUMW'(st_sel_c >> 1) + SUMW'(cur_sel_c);
    assign sat_c     = sum_c[WIDTH] ? {WIDTH{1'b1}} : sum_c[WIDTH-1:0];
    assign fire_c    = (sum_c >= SUMW'(THRESHOLD));

`ifdef LIF_REFRACTORY_EN
    localparam int unsigned RW = $clog2(REFRAC_STEPS + 1);

    logic [RW-1:0] refr_q [N_NEURONS];
    logic [RW-1:0] refr_sel_c;
    logic          refr_act_c;

    assign refr_sel_c  = refr_q[idx_q];
    assign refr_act_c  = (refr_sel_c != '0);
    assign spike_c     = fire_c && !refr_act_c;
    assign new_state_c = (fire_c || refr_act_c) ? '0 : sat_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_NEURONS; i++) refr_q[i] <= '0;
        end else if (upd_c) begin
            if (refr_act_c)
                refr_q[idx_q] <= refr_sel_c - RW'(1);
            else if (fire_c)
                refr_q[idx_q] <= RW'(REFRAC_STEPS);
        end
    end
`else
    // Refractory length has no meaning without counters; keep it referenced
    logic unused_refrac;
    assign unused_refrac = (REFRAC_STEPS == 0);
    assign spike_c       = fire_c;
    assign new_state_c   = fire_c ? '0 : sat_c;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                state_q[i] <= '0;
                cur_q[i]   <= '0;
            end
            idx_q     <= '0;
            acc_q     <= '0;
            spike_vec <= '0;
        end else begin
            if (cur_wr_en) cur_q[cur_wr_idx] <= cur_wr_data;
            if (start_c) begin
                idx_q <= '0;
                acc_q <= '0;
            end else if (upd_c) begin
                state_q[idx_q] <= new_state_c;
                acc_q[idx_q]   <= spike_c;
                if (!last_c) idx_q <= idx_q + IDXW'(1);
            end
            if (fsm_q == FINISH) spike_vec <= acc_q;
        end
    end

endmodule

// File: tb/tb_lif_step_scheduler.sv
// Scoreboard bench for lif_step_scheduler: stimulus pushes expected spike_vec/state,
// a monitor pops and compares after each done pulse.
module tb_lif_step_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cur_wr_en;
    logic [1:0] cur_wr_idx;
    logic [7:0] cur_wr_data;
    logic       step;
    logic       busy, done;
    logic [3:0] spike_vec;
    logic [1:0] rd_idx, main_idx, mon_idx;
    logic       mon_active;
    logic [7:0] rd_state;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0] sv;
        logic [1:0] idx;
        logic [7:0] st;
    } exp_t;
    exp_t exp_q[$];

    lif_step_scheduler #(
        .N_NEURONS(4), .WIDTH(8), .THRESHOLD(200), .REFRAC_STEPS(2)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cur_wr_en(cur_wr_en), .cur_wr_idx(cur_wr_idx), .cur_wr_data(cur_wr_data),
        .step(step), .busy(busy), .done(done), .spike_vec(spike_vec),
        .rd_idx(rd_idx), .rd_state(rd_state)
    );

    always #5 clk = ~clk;

    always_comb rd_idx = mon_active ? mon_idx : main_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic push_exp(input logic [3:0] sv, input logic [1:0] idx, input logic [7:0] st);
        exp_t e;
        e.sv = sv; e.idx = idx; e.st = st;
        exp_q.push_back(e);
    endtask

    task automatic wr_cur(input logic [1:0] idx, input logic [7:0] data);
        @(negedge clk);
        cur_wr_en = 1'b1; cur_wr_idx = idx; cur_wr_data = data;
        @(negedge clk);
        cur_wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) begin
            n_checks++;
            $display("FAIL sweep_timeout: busy=%0b done=%0b after %0d cycles", busy, done, n);
        end
    endtask

    task automatic do_step(input logic [3:0] sv, input logic [1:0] idx, input logic [7:0] st);
        push_exp(sv, idx, st);
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: on done, pop the expected entry and compare once spike_vec has latched
    initial begin
        exp_t e;
        mon_active = 1'b0;
        mon_idx    = '0;
        forever begin
            @(negedge clk);
            if (reset_n && done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: done=1 with empty scoreboard at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    mon_idx    = e.idx;
                    mon_active = 1'b1;
                    @(negedge clk);
                    check("spike_vec", 32'(spike_vec), 32'(e.sv));
                    check($sformatf("state[%0d]", e.idx), 32'(rd_state), 32'(e.st));
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [7:0] exp_b [10];
        logic [7:0] exp_c [7];
        int n;
        exp_b = '{100, 150, 175, 187, 193, 196, 198, 199, 199, 199};
        exp_c = '{101, 151, 176, 189, 195, 198, 0};

        reset_n = 1'b0; cur_wr_en = 1'b0; cur_wr_idx = '0; cur_wr_data = '0;
        step = 1'b0; main_idx = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_spike_vec", 32'(spike_vec), 0);
        reset_n = 1'b1;

        // Reset mid-sweep
        wr_cur(2'd0, 8'd100);
        wr_cur(2'd1, 8'd7);
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        @(negedge clk);
        check("midsweep_busy", 32'(busy), 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("inrst_busy", 32'(busy), 0);
        check("inrst_done", 32'(done), 0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            main_idx = 2'(i);
            #1;
            check($sformatf("postrst_state[%0d]", i), 32'(rd_state), 0);
        end
        check("postrst_spike_vec", 32'(spike_vec), 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("postrst_no_done", 32'(done), 0);
        end
        // Currents were cleared too, so a step leaves state[0] at zero
        do_step(4'b0000, 2'd0, 8'd0);

        // Sub-threshold convergence
        wr_cur(2'd0, 8'd100);
        for (int s = 0; s < 10; s++) do_step(4'b0000, 2'd0, exp_b[s]);

        // Threshold crossing on step 7
        do_reset();
        wr_cur(2'd1, 8'd101);
        for (int s = 0; s < 7; s++) do_step((s == 6) ? 4'b0010 : 4'b0000, 2'd1, exp_c[s]);

        // Handshake: step held high, one sweep per IDLE visit
        do_reset();
        push_exp(4'b0000, 2'd0, 8'd0);
        push_exp(4'b0000, 2'd0, 8'd0);
        @(negedge clk);
        step = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("hs_busy_k%0d", k), 32'(busy), ((k % 6) != 0) ? 1 : 0);
            check($sformatf("hs_done_k%0d", k), 32'(done), ((k % 6) == 5) ? 1 : 0);
        end
        step = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hs_idle_after", 32'(busy), 0);
        end

        // Saturating current: refractory gating when compiled in
        do_reset();
        wr_cur(2'd2, 8'd255);
        for (int s = 1; s <= 9; s++) begin
`ifdef LIF_REFRACTORY_EN
            do_step(((s % 3) == 1) ? 4'b0100 : 4'b0000, 2'd2, 8'd0);
`else
            do_step(4'b0100, 2'd2, 8'd0);
`endif
        end

        // Current write colliding with neuron 3's update cycle
        do_reset();
        push_exp(4'b0000, 2'd3, 8'd0);
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        cur_wr_en = 1'b1; cur_wr_idx = 2'd3; cur_wr_data = 8'd50;
        @(negedge clk);
        cur_wr_en = 1'b0;
        wait_idle();
        do_step(4'b0000, 2'd3, 8'd50);

        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("scoreboard_drain", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lif_step_scheduler.md
Name: lif_step_scheduler

Overview:
- Time-multiplexed controller for leaky integrate-and-fire neurons.
- One shared leak/integrate/fire datapath serves N_NEURONS virtual neurons. Membrane state and input current for each neuron live in internal register files.
- On each `step` request, an FSM sweeps the neurons one per cycle, updates their states and collects spikes into a vector. It pulses `done` when the sweep finishes.
- Sits between the top-level I/O wrapper (current loading, step trigger) and the spike/state outputs.

Parameters:
- N_NEURONS, 4, number of virtual neurons (power of 2, >=2); IDXW = log2(N_NEURONS).
- WIDTH, 8, bit width of membrane state and input current.
- THRESHOLD, 200, firing threshold (unsigned, 1..2^WIDTH-1).
- REFRAC_STEPS, 2, refractory length in time steps (used only with LIF_REFRACTORY_EN).

Ports:
- clk, input, 1, clock.
- reset_n, input, 1, asynchronous active-low reset.
- cur_wr_en, input, 1, write strobe for the current register file.
- cur_wr_idx, input, IDXW, neuron index to write.
- cur_wr_data, input, WIDTH, input current value.
- step, input, 1, request one time step (level sampled each cycle).
- busy, output, 1, high while a sweep is in progress.
- done, output, 1, one-cycle pulse when a sweep completes.
- spike_vec, output, N_NEURONS, spikes from the last completed sweep; bit i = neuron i.
- rd_idx, input, IDXW, state readback index.
- rd_state, output, WIDTH, combinational read of state[rd_idx].

Behaviour:
- Clock and reset: one clock `clk`; asynchronous, active-low reset `reset_n`.
- Reset values:
  - state[*]=0, current[*]=0, spike_vec=0, busy=0, done=0.
  - Internal index=0, spike accumulator=0, refractory counters=0.
  - FSM=IDLE.
- FSM states: IDLE, SWEEP, FINISH.
  - IDLE: if `step`=1, go to SWEEP, clear the accumulator, set idx=0. Otherwise stay.
  - SWEEP: update neuron idx this cycle. If idx==N_NEURONS-1, go to FINISH; else idx+1.
  - FINISH:
    - spike_vec <= accumulator.
    - done=1 for this cycle only.
    - go to IDLE.
    - spike_vec holds its value until the next FINISH.
- Timing: `step` sampled high in IDLE at edge t ->
  - busy=1 for cycles t+1 .. t+N_NEURONS+1 (SWEEP plus FINISH).
  - done=1 in cycle t+N_NEURONS+1.
  - The earliest next step is accepted at edge t+N_NEURONS+2.
- `step` while busy is ignored, not queued.
- Neuron update in the SWEEP cycle for neuron i:
  - sum = (state[i] >> 1) + current[i], computed at WIDTH+1 bits and saturated to 2^WIDTH-1.
  - If sum >= THRESHOLD: state[i] <= 0 and accumulator bit i <= 1.
  - Else: state[i] <= sum and accumulator bit i <= 0.
- Current writes:
  - Accepted in any FSM state; take effect at the next edge.
  - If a write targets the neuron being updated in the same cycle, the update uses the old current.
  - Current values persist across steps until rewritten.
- rd_state:
  - Purely combinational from the state file.
  - A read of the neuron being updated shows the pre-update value until the edge.
- Reset mid-sweep:
  - Immediate return to reset values.
  - No done pulse.
  - Partial updates are discarded, because all state is cleared.

Optional Feature:
- Macro: LIF_REFRACTORY_EN.
- Defined:
  - Each neuron has a counter ceil(log2(REFRAC_STEPS+1)) bits wide.
  - On a spike, the counter is loaded with REFRAC_STEPS.
  - In a sweep where the counter is nonzero: state held at 0, current ignored, no spike, counter decremented by 1.
  - Counters reset to 0.
- Undefined:
  - No counters exist.
  - A neuron is eligible to integrate and fire every step.

Test Plan:
- Reset: assert reset_n=0 mid-sweep, release -> busy=0, done=0, spike_vec=0, rd_state=0 for all indices; no done pulse.
- Sub-threshold convergence: current[0]=100, 10 steps -> state[0] = 100,150,175,187,193,196,198,199,199,199; spike_vec[0] stays 0.
- Threshold crossing: current[1]=101 -> state[1] = 101,151,176,189,195,198, then spike on step 7 (sum=200); state[1]=0 and spike_vec=4'b0010 after step 7.
- Handshake timing: step pulse at edge t with N=4 -> busy high t+1..t+5, done only at t+5; step held high during busy causes exactly one sweep per IDLE visit, with the next sweep starting at t+6.
- Refractory: current[2]=255, 9 steps back-to-back:
  - Without the macro, spike_vec[2]=1 on every step.
  - With LIF_REFRACTORY_EN and REFRAC_STEPS=2, spikes on steps 1, 4 and 7 only, and state[2]=0 in between.
- Write collision: during the SWEEP cycle for neuron 3, write current[3]=50 (old value 0) -> that step leaves state[3]=0; the next step gives state[3]=50.
